eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
Frame-level arbiter sharing the single 64-bit MAC TX AXI-Stream between three transmit sources: ARP TX (src 0), ICMP TX (src 1) and UDP TX (src 2).
- Grants one source per frame: ARP has strict priority; ICMP/UDP alternate round-robin.
- Registered output slice toward the MAC.
- Stall watchdog: a granted source that stops mid-frame gets its frame aborted with an error beat, and its remainder is drained.
- Sits between the protocol TX modules and the MAC, mirroring the RX-side demux path.

Parameters:
DATA_W, 64, tdata width; tkeep is DATA_W/8.
TIMEOUT_CYCLES, 1024, consecutive cycles with granted tvalid low mid-frame before abort; range 2..65535.

Ports:
tx_axis_aclk  in  1  single clock, all logic rising edge.
tx_axis_areset  in  1  synchronous, active-high reset.
s_axis_tdata  in  3*DATA_W  source data, slice i = source i (0 ARP, 1 ICMP, 2 UDP).
s_axis_tkeep  in  3*DATA_W/8  per-source byte enables.
s_axis_tvalid  in  3  per-source valid.
s_axis_tlast  in  3  per-source end of frame.
s_axis_tuser  in  3  per-source error flag, passed through.
s_axis_tready  out  3  per-source ready.
mac_tx_axis_tdata  out  DATA_W  to MAC.
mac_tx_axis_tkeep  out  DATA_W/8  to MAC.
mac_tx_axis_tvalid  out  1  to MAC.
mac_tx_axis_tlast  out  1  to MAC.
mac_tx_axis_tuser  out  1  to MAC; 1 marks a frame the MAC must discard.
mac_tx_axis_tready  in  1  MAC backpressure.
grant  out  3  one-hot current owner; 0 when idle.
abort_cnt  out  16  saturating count of watchdog aborts.

Behaviour:
- Reset values (synchronous, on tx_axis_areset=1):
  - All outputs 0; state IDLE.
  - rr_last=2, so ICMP wins the first ICMP/UDP tie.
  - Watchdog count 0.
- Output slice: one register stage.
  - Load when (!mac_tx_axis_tvalid || mac_tx_axis_tready).
  - s_axis_tready[i] = (grant[i] && slice_free && state==PASS) || (state==DRAIN && grant[i]).
  - Input-to-MAC latency is 1 cycle. Full throughput is 1 beat/cycle with tready held high.
- State IDLE:
  - Evaluate s_axis_tvalid.
  - If src 0 is valid, grant 0.
  - Otherwise, if exactly one of src 1/2 is valid, grant it.
  - If both are valid, grant the one not equal to rr_last.
  - The grant registers at the clock edge; next state is PASS. No beat is accepted in the IDLE cycle, so arbitration costs 1 cycle per frame.
- State PASS:
  - Forward the granted source's beats unchanged.
  - On an accepted beat with tlast: clear grant, set rr_last=granted index (src 1/2 only), go to IDLE.
  - The grant never changes mid-frame, whatever the other sources' requests.
- Watchdog (active in PASS only):
  - Counts cycles where the granted tvalid=0. Resets on any accepted beat.
  - Cycles where the output slice is full and the MAC is stalling do not count.
  - At TIMEOUT_CYCLES, go to ABORT.
- State ABORT:
  - Load one beat into the slice: tdata=0, tkeep=8'h01, tlast=1, tuser=1.
  - The load waits for slice_free.
  - Increment abort_cnt, saturating at 16'hFFFF.
  - Next state is DRAIN.
- State DRAIN:
  - Keep the grant. Accept and discard granted-source beats (not forwarded) until a beat with tlast.
  - On that tlast: clear grant, go to IDLE.
  - DRAIN has no timeout; an abandoned source blocks until it sends tlast.
- Boundary conditions:
  - A timeout and a valid beat arriving in the same cycle: the beat wins; no abort.
  - A single-beat frame (tlast on its first beat) is legal.
  - Reset mid-frame: the slice is emptied, grant drops and the FSM returns to IDLE. The partial frame is not terminated; the MAC relies on its own reset.
  - tuser is passed through transparently in PASS.

Decomposition:
- Package eth_tx_pkg holds:
  - Source index constants SRC_ARP=0, SRC_ICMP=1, SRC_UDP=2.
  - The FSM state encoding (IDLE, PASS, ABORT, DRAIN).
  - The abort-beat constants: tkeep 8'h01, tuser 1.
- One sub-module, axis_reg_slice: the 1-deep registered output stage with tready pass-back.

Test Plan:
- All sources idle, ARP sends a 6-beat frame with tready=1 -> grant=3'b001. The first beat appears at the MAC 2 cycles after tvalid rises (1 arbitration + 1 slice). All 6 beats are contiguous, then grant=0.
- ICMP and UDP assert together, each with 3-beat frames, repeated twice -> MAC frame order is ICMP, UDP, ICMP, UDP; no interleaved beats.
- UDP is mid-frame (beat 2 of 8) when ARP asserts -> UDP completes all 8 beats; then the ARP frame follows.
- MAC tready toggles 1/0 every cycle during a 10-beat UDP frame -> all 10 beats arrive in order with no duplicates or drops; no watchdog abort occurs.
- TIMEOUT_CYCLES=16; ICMP sends 2 beats, then holds tvalid low for 16 cycles -> the MAC receives 2 beats, then a beat with tkeep=8'h01, tlast=1, tuser=1; abort_cnt=1. ICMP's remaining 3 beats (last with tlast) are accepted and not forwarded; then IDLE.
- tx_axis_areset is pulsed for 1 cycle at beat 3 of a 5-beat ARP frame -> the next cycle shows mac_tx_axis_tvalid=0, grant=0 and abort_cnt=0. A fresh frame afterwards arbitrates normally.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared constants for the Ethernet TX arbiter: source indices,
// arbiter FSM encoding and the abort-beat signature.
package eth_tx_pkg;

    localparam int N_SRC = 3;

    localparam logic [1:0] SRC_ARP  = 2'd0;
    localparam logic [1:0] SRC_ICMP = 2'd1;
    localparam logic [1:0] SRC_UDP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic [7:0] ABORT_TKEEP = 8'h01;
    localparam logic       ABORT_TUSER = 1'b1;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered AXI-Stream stage; accepts a new beat whenever
// the held beat is absent or being taken downstream.
module axis_reg_slice #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    input  logic                s_tuser,
    output logic                s_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tvalid,
    output logic                m_tlast,
    output logic                m_tuser,
    input  logic                m_tready
);

    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tkeep <= s_tkeep;
                m_tlast <= s_tlast;
                m_tuser <= s_tuser;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter for ARP/ICMP/UDP onto the MAC TX stream,
// with a mid-frame stall watchdog that aborts and drains the owner.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  tx_axis_aclk,
    input  logic                  tx_axis_areset,
    input  logic [3*DATA_W-1:0]   s_axis_tdata,
    input  logic [3*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [2:0]            s_axis_tvalid,
    input  logic [2:0]            s_axis_tlast,
    input  logic [2:0]            s_axis_tuser,
    output logic [2:0]            s_axis_tready,
    output logic [DATA_W-1:0]     mac_tx_axis_tdata,
    output logic [DATA_W/8-1:0]   mac_tx_axis_tkeep,
    output logic                  mac_tx_axis_tvalid,
    output logic                  mac_tx_axis_tlast,
    output logic                  mac_tx_axis_tuser,
    input  logic                  mac_tx_axis_tready,
    output logic [2:0]            grant,
    output logic [15:0]           abort_cnt
);

    localparam int          KEEP_W  = DATA_W / 8;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t state, state_nxt;
    logic [2:0]  grant_nxt;
    logic [1:0]  rr_last, rr_last_nxt;
    logic [15:0] wd_cnt, wd_cnt_nxt, abort_cnt_nxt;

    logic [DATA_W-1:0] sel_tdata;
    logic [KEEP_W-1:0] sel_tkeep;
    logic              sel_tvalid, sel_tlast, sel_tuser;
    logic [1:0]        sel_idx;

    logic [DATA_W-1:0] sl_tdata;
    logic [KEEP_W-1:0] sl_tkeep;
    logic              sl_tvalid, sl_tlast, sl_tuser, slice_free;
    logic              pass_fire;

    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tuser  = 1'b0;
        sel_idx    = SRC_ARP;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_tdata  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
                sel_tuser  = s_axis_tuser[i];
                sel_idx    = 2'(i);
            end
        end
    end

    assign pass_fire = (state == PASS) && sel_tvalid && slice_free;

    assign s_axis_tready = grant &
        {3{((state == PASS) && slice_free) || (state == DRAIN)}};

    // Only PASS forwards source beats; ABORT injects the error terminator.
    always_comb begin
        sl_tvalid = (state == PASS) && sel_tvalid;
        sl_tdata  = sel_tdata;
        sl_tkeep  = sel_tkeep;
        sl_tlast  = sel_tlast;
        sl_tuser  = sel_tuser;
        if (state == ABORT) begin
            sl_tvalid = 1'b1;
            sl_tdata  = '0;
            sl_tkeep  = KEEP_W'(ABORT_TKEEP);
            sl_tlast  = 1'b1;
            sl_tuser  = ABORT_TUSER;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_last_nxt   = rr_last;
        wd_cnt_nxt    = wd_cnt;
        abort_cnt_nxt = abort_cnt;
        unique case (state)
            IDLE: begin
                wd_cnt_nxt = '0;
                if (s_axis_tvalid[SRC_ARP])
                    grant_nxt = 3'b001;
                else if (s_axis_tvalid[SRC_ICMP] && s_axis_tvalid[SRC_UDP])
                    grant_nxt = (rr_last == SRC_ICMP) ? 3'b100 : 3'b010;
                else if (s_axis_tvalid[SRC_ICMP])
                    grant_nxt = 3'b010;
                else if (s_axis_tvalid[SRC_UDP])
                    grant_nxt = 3'b100;
                if (|s_axis_tvalid)
                    state_nxt = PASS;
            end
            PASS: begin
                if (pass_fire) begin
                    wd_cnt_nxt = '0;
                    if (sel_tlast) begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                        if (sel_idx != SRC_ARP)
                            rr_last_nxt = sel_idx;
                    end
                end else if (!sel_tvalid && slice_free) begin
                    // A stalled MAC is not the source's fault: no count then.
                    if (wd_cnt == WD_LAST) begin
                        wd_cnt_nxt = '0;
                        state_nxt  = ABORT;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 16'd1;
                    end
                end
            end
            ABORT: begin
                if (slice_free) begin
                    state_nxt = DRAIN;
                    if (abort_cnt != 16'hFFFF)
                        abort_cnt_nxt = abort_cnt + 16'd1;
                end
            end
            DRAIN: begin
                if (sel_tvalid && sel_tlast) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_last   <= SRC_UDP;
            wd_cnt    <= '0;
            abort_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_last   <= rr_last_nxt;
            wd_cnt    <= wd_cnt_nxt;
            abort_cnt <= abort_cnt_nxt;
        end
    end

    axis_reg_slice #(
        .DATA_W(DATA_W)
    ) u_slice (
        .clk      (tx_axis_aclk),
        .rst      (tx_axis_areset),
        .s_tdata  (sl_tdata),
        .s_tkeep  (sl_tkeep),
        .s_tvalid (sl_tvalid),
        .s_tlast  (sl_tlast),
        .s_tuser  (sl_tuser),
        .s_tready (slice_free),
        .m_tdata  (mac_tx_axis_tdata),
        .m_tkeep  (mac_tx_axis_tkeep),
        .m_tvalid (mac_tx_axis_tvalid),
        .m_tlast  (mac_tx_axis_tlast),
        .m_tuser  (mac_tx_axis_tuser),
        .m_tready (mac_tx_axis_tready)
    );

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-source expected-beat queues,
// a frame-level arbitration model and directed watchdog/reset scenarios.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

    localparam int DATA_W = 64;
    localparam int TMO    = 16;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [191:0] s_tdata;
    logic [23:0]  s_tkeep;
    logic [2:0]   s_tvalid, s_tlast, s_tuser, s_tready;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         m_tvalid, m_tlast, m_tuser;
    logic         m_tready = 1'b1;
    logic [2:0]   grant;
    logic [15:0]  abort_cnt;

    beat_t src_beat [3];
    logic  src_valid [3];

    for (genvar g = 0; g < 3; g++) begin : g_src
        assign s_tdata[g*64 +: 64] = src_beat[g].d;
        assign s_tkeep[g*8 +: 8]   = src_beat[g].k;
        assign s_tlast[g]          = src_beat[g].l;
        assign s_tuser[g]          = src_beat[g].u;
        assign s_tvalid[g]         = src_valid[g];
    end

    eth_tx_arbiter #(
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .tx_axis_aclk       (clk),
        .tx_axis_areset     (rst),
        .s_axis_tdata       (s_tdata),
        .s_axis_tkeep       (s_tkeep),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tlast       (s_tlast),
        .s_axis_tuser       (s_tuser),
        .s_axis_tready      (s_tready),
        .mac_tx_axis_tdata  (m_tdata),
        .mac_tx_axis_tkeep  (m_tkeep),
        .mac_tx_axis_tvalid (m_tvalid),
        .mac_tx_axis_tlast  (m_tlast),
        .mac_tx_axis_tuser  (m_tuser),
        .mac_tx_axis_tready (m_tready),
        .grant              (grant),
        .abort_cnt          (abort_cnt)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic die(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $fatal(1, "stopped");
    endtask

    beat_t exp0[$], exp1[$], exp2[$];

    task automatic push_exp(input int s, input beat_t b);
        case (s)
            0: exp0.push_back(b);
            1: exp1.push_back(b);
            default: exp2.push_back(b);
        endcase
    endtask

    function automatic int exp_size(input int s);
        case (s)
            0: return exp0.size();
            1: return exp1.size();
            2: return exp2.size();
            default: return 0;
        endcase
    endfunction

    function automatic beat_t exp_pop(input int s);
        case (s)
            0: return exp0.pop_front();
            1: return exp1.pop_front();
            default: return exp2.pop_front();
        endcase
    endfunction

    // Monitor: every beat the MAC takes is matched against its source queue.
    bit    mon_en = 1'b1;
    bit    in_frame = 1'b0;
    int    cur_src = 0;
    int    frame_first_cyc = 0;
    int    frame_last_cyc = 0;
    int    order_q[$];
    beat_t got, want;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_frame = 1'b0;
        end else if (mon_en && m_tvalid && m_tready) begin
            got = {m_tdata, m_tkeep, m_tlast, m_tuser};
            if (!in_frame) begin
                cur_src = int'(m_tdata[63:62]);
                in_frame = 1'b1;
                frame_first_cyc = cyc;
                order_q.push_back(cur_src);
            end
            if (exp_size(cur_src) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mac beat src%0d: got %0h expected none",
                         cur_src, got);
            end else begin
                want = exp_pop(cur_src);
                check($sformatf("mac beat src%0d", cur_src), got, want);
            end
            if (m_tlast) begin
                in_frame = 1'b0;
                frame_last_cyc = cyc;
            end
        end
    end

    // Arbitration model: ARP first, else ICMP/UDP alternate by last
    // normally completed frame.
    int         rr_model = 2;
    bit         pend = 1'b0;
    logic [2:0] pend_g;
    bit         aborting [3];

    function automatic logic [2:0] arb(input logic [2:0] v, input int rr);
        if (v[0]) return 3'b001;
        if (v[1] && v[2]) return (rr == 1) ? 3'b100 : 3'b010;
        if (v[1]) return 3'b010;
        if (v[2]) return 3'b100;
        return 3'b000;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst) begin
            rr_model = 2;
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("grant arb", grant, pend_g);
                pend = 1'b0;
            end
            if (grant == 3'b000 && s_tvalid != 3'b000) begin
                pend = 1'b1;
                pend_g = arb(s_tvalid, rr_model);
            end
            for (int i = 1; i < 3; i++)
                if (grant[i] && s_tvalid[i] && s_tready[i] && s_tlast[i]
                    && !aborting[i])
                    rr_model = i;
        end
    end

    int mac_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (mac_mode)
            0: m_tready = 1'b1;
            1: m_tready = !m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    int frame_seq = 0;
    int exp_aborts = 0;
    int start_cyc [3];

    task automatic send_frame(input int s, input int n, input int gap_max,
                              input int stall_after, input int stall_len);
        beat_t b[$];
        beat_t t;
        int    seq;
        int    nw;
        bit    ab;
        seq = frame_seq;
        frame_seq++;
        ab = (stall_after > 0) && (stall_len >= TMO);
        for (int j = 0; j < n; j++) begin
            t.d = {2'(s), 14'(seq), 8'(j), 8'h00, 32'($urandom())};
            t.k = (j == n - 1) ? 8'($urandom_range(1, 255)) : 8'hff;
            t.l = (j == n - 1);
            t.u = ($urandom_range(0, 9) == 0);
            b.push_back(t);
        end
        if (ab) begin
            for (int j = 0; j < stall_after; j++) push_exp(s, b[j]);
            push_exp(s, {64'h0, 8'h01, 1'b1, 1'b1});
            exp_aborts++;
            aborting[s] = 1'b1;
        end else begin
            for (int j = 0; j < n; j++) push_exp(s, b[j]);
        end
        for (int j = 0; j < n; j++) begin
            src_beat[s] = b[j];
            src_valid[s] = 1'b1;
            if (j == 0) start_cyc[s] = cyc;
            nw = 0;
            forever begin
                @(negedge clk);
                if (s_tready[s]) break;
                nw++;
                if (nw > 3000) die($sformatf("tready src%0d", s));
            end
            @(posedge clk);
            #1;
            src_valid[s] = 1'b0;
            if (stall_len > 0 && j == stall_after - 1) begin
                repeat (stall_len) begin @(posedge clk); #1; end
            end else if (j < n - 1 && gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
        end
        aborting[s] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp0.size() == 0 && exp1.size() == 0 && exp2.size() == 0
                 && grant == 3'b000 && !m_tvalid)) begin
            @(negedge clk);
            n++;
            if (n > 2000) die("drain to idle");
        end
        @(posedge clk);
        #1;
    endtask

    int exp_o [4] = '{1, 2, 1, 2};

    initial begin
        #500000;
        die("global time limit");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            src_beat[i] = '0;
            src_valid[i] = 1'b0;
            aborting[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset tvalid", m_tvalid, 1'b0);
        check("reset grant", grant, 3'b000);
        check("reset abort_cnt", abort_cnt, 16'd0);
        check("reset s_tready", s_tready, 3'b000);
        check("reset tdata", m_tdata, 64'd0);
        @(posedge clk);
        #1;

        // ARP alone: 2-cycle latency, contiguous 6 beats
        send_frame(0, 6, 0, 0, 0);
        wait_idle();
        check("arp latency", frame_first_cyc - start_cyc[0], 2);
        check("arp contiguous", frame_last_cyc - frame_first_cyc, 5);
        check("arp grant idle", grant, 3'b000);

        // ICMP and UDP contend: strict alternation
        order_q.delete();
        fork
            begin send_frame(1, 3, 0, 0, 0); send_frame(1, 3, 0, 0, 0); end
            begin send_frame(2, 3, 0, 0, 0); send_frame(2, 3, 0, 0, 0); end
        join
        wait_idle();
        check("rr frame count", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check($sformatf("rr order %0d", i), order_q[i], exp_o[i]);

        // ARP arrives mid-UDP frame: UDP is not preempted
        order_q.delete();
        fork
            send_frame(2, 8, 0, 0, 0);
            begin
                repeat (4) begin @(posedge clk); #1; end
                send_frame(0, 4, 0, 0, 0);
            end
        join
        wait_idle();
        check("preempt count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("preempt first", order_q[0], 2);
            check("preempt second", order_q[1], 0);
        end

        // MAC tready toggling during a 10-beat UDP frame
        mac_mode = 1;
        send_frame(2, 10, 0, 0, 0);
        wait_idle();
        mac_mode = 0;
        check("toggle no abort", abort_cnt, exp_aborts);

        // ICMP stalls for exactly the timeout: abort then drain
        send_frame(1, 5, 0, 2, TMO);
        wait_idle();
        check("abort count", abort_cnt, exp_aborts);
        check("abort grant idle", grant, 3'b000);

        // Stall one cycle short: the arriving beat wins
        send_frame(1, 4, 0, 2, TMO - 1);
        wait_idle();
        check("near timeout", abort_cnt, exp_aborts);

        // Reset during beat 3 of an ARP frame
        mon_en = 1'b0;
        src_beat[0] = {64'h0, 8'hff, 1'b0, 1'b0};
        src_valid[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid[0] = 1'b0;
        exp_aborts = 0;
        @(negedge clk);
        check("midreset tvalid", m_tvalid, 1'b0);
        check("midreset grant", grant, 3'b000);
        check("midreset abort_cnt", abort_cnt, 16'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send_frame(0, 3, 0, 0, 0);
        wait_idle();
        check("post reset latency", frame_first_cyc - start_cyc[0], 2);

        // Randomized traffic with random MAC backpressure
        mac_mode = 2;
        fork
            for (int s = 0; s < 3; s++) begin
                fork
                    automatic int src = s;
                    for (int f = 0; f < 8; f++) begin
                        send_frame(src, $urandom_range(1, 8), 2, 0, 0);
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk); #1;
                        end
                    end
                join_none
            end
        join_none
        wait fork;
        wait_idle();
        mac_mode = 0;
        check("random no abort", abort_cnt, exp_aborts);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
